// File: rtl/b2_mod_counter.sv
// Base-2 modulo-MOD up/down counter with synchronous clamped load, chainable
// terminal-count carry and sticky wrap flag. Define B2_MOD_COUNTER_SATURATE_EN to saturate instead of wrap.
module b2_mod_counter #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] q,
    output logic         cout,
    output logic         ovf
);

    localparam logic [N-1:0] MAXV = N'(MOD - 1);

    logic [N-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         at_top, at_bot, term;
    logic [N-1:0] inc, dec;

    function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Value taken on a terminal edge: the wrap target, or the held terminal when saturating.
    function automatic logic [N-1:0] terminal_next(input logic dir_up);
`ifdef B2_MOD_COUNTER_SATURATE_EN
        return dir_up ? MAXV : '0;
`else
        return dir_up ? '0 : MAXV;
`endif
    endfunction

    assign at_top = (count_q == MAXV);
    assign at_bot = (count_q == '0);
    assign term   = up ? at_top : at_bot;
    assign inc    = count_q + N'(1);
    assign dec    = count_q - N'(1);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = clamp_load(d);
            ovf_d   = 1'b0;
        end else if (en) begin
            if (term) begin
                count_d = terminal_next(up);
                ovf_d   = 1'b1;
            end else if (up) begin
                // An out-of-range count (unreachable) recovers to 0 when counting up.
                count_d = (count_q > MAXV) ? '0 : inc;
            end else begin
                count_d = dec;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q    = count_q;
    assign ovf  = ovf_q;
    assign cout = reset_ & en & ~load & term;

endmodule

// File: tb/tb_b2_mod_counter.sv
// Directed self-checking bench for b2_mod_counter (N=4, MOD=10), single stage and two-stage cascade.
module tb_b2_mod_counter;

`ifdef B2_MOD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_;
    logic       load, en, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       cout, ovf;

    logic       casc_en, casc_up;
    logic [3:0] lo_q, hi_q;
    logic       lo_cout, hi_cout, lo_ovf, hi_ovf;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    b2_mod_counter #(.N(4), .MOD(10)) dut (
        .clock(clock), .reset_(reset_), .load(load), .d(d), .en(en), .up(up),
        .q(q), .cout(cout), .ovf(ovf)
    );

    b2_mod_counter #(.N(4), .MOD(10)) lo (
        .clock(clock), .reset_(reset_), .load(1'b0), .d(4'd0), .en(casc_en), .up(casc_up),
        .q(lo_q), .cout(lo_cout), .ovf(lo_ovf)
    );

    b2_mod_counter #(.N(4), .MOD(10)) hi (
        .clock(clock), .reset_(reset_), .load(1'b0), .d(4'd0), .en(lo_cout), .up(casc_up),
        .q(hi_q), .cout(hi_cout), .ovf(hi_ovf)
    );

    typedef struct {
        logic       load;
        logic [3:0] d;
        logic       en;
        logic       up;
        logic       exp_cout;
        logic [3:0] exp_q;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #12;
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    initial begin
        reset_  = 1'b0;
        load    = 1'b0;
        d       = 4'd0;
        en      = 1'b1;
        up      = 1'b0;
        casc_en = 1'b0;
        casc_up = 1'b1;

        //        load d      en    up    cout  q                   ovf
        vecs[0]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd9,               1'b0};
        vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, SAT ? 4'd9 : 4'd0,  1'b1};
        vecs[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,               1'b0};
        vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,               1'b0};
        vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd1,               1'b0};
        vecs[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,               1'b0};
        vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, SAT ? 4'd0 : 4'd9,  1'b1};
        vecs[7]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3,               1'b0};
        vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd2,               1'b0};
        vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd3,               1'b0};
        vecs[10] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd9,               1'b0};
        vecs[11] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd9,               1'b0};
        vecs[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8,               1'b0};
        vecs[13] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,               1'b0};

        // Reset state; en=1/up=0 at q=0 would raise cout if it were not forced low.
        #3;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        en = 1'b0;
        do_reset();

        // Table-driven vectors: cout checked before the edge, q/ovf after it.
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            load = vecs[i].load;
            d    = vecs[i].d;
            en   = vecs[i].en;
            up   = vecs[i].up;
            #1;
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
        end

        // Up-count 11 edges from reset: wrap 9->0 (or stick at 9 when saturating).
        @(negedge clock);
        load = 1'b0; en = 1'b0; up = 1'b1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk($sformatf("up%0d_cout", i), 32'(cout), 32'((SAT ? (i >= 9) : (i == 9)) ? 1 : 0));
            @(posedge clock);
            #1;
            chk($sformatf("up%0d_q", i), 32'(q),
                SAT ? 32'((i + 1 > 9) ? 9 : i + 1) : 32'((i + 1) % 10));
            chk($sformatf("up%0d_ovf", i), 32'(ovf), 32'((i + 1 >= 10) ? 1 : 0));
            @(negedge clock);
        end

        // Reach q=6 with ovf set, then a half-cycle asynchronous reset pulse.
        en = 1'b0;
        do_reset();
        en = 1'b1; up = 1'b0;
        @(posedge clock);
        @(negedge clock);
        up = 1'b1;
        repeat (SAT ? 6 : 7) @(posedge clock);
        #1;
        chk("pre_rst_q", 32'(q), 32'd6);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        #2 reset_ = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_q", 32'(q), 32'd1);

        // Two-stage cascade for 100 edges.
        @(negedge clock);
        en = 1'b0;
        do_reset();
        casc_en = 1'b1;
        repeat (99) @(posedge clock);
        #1;
        chk("casc99_lo", 32'(lo_q), 32'd9);
        chk("casc99_hi", 32'(hi_q), 32'd9);
        chk("casc99_hi_cout", 32'(hi_cout), 32'd1);
        @(posedge clock);
        #1;
        chk("casc100_lo", 32'(lo_q), SAT ? 32'd9 : 32'd0);
        chk("casc100_hi", 32'(hi_q), SAT ? 32'd9 : 32'd0);
        chk("casc100_lo_ovf", 32'(lo_ovf), 32'd1);
        chk("casc100_hi_ovf", 32'(hi_ovf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
